// File: rtl/alu_pkg.sv
// Purpose : shared opcode definitions for the W-bit unsigned ALU.
// Latency : n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_MUL = 4'd2;
  localparam op_t OP_DIV = 4'd3;
  localparam op_t OP_MOD = 4'd4;
  localparam op_t OP_AND = 4'd5;
  localparam op_t OP_OR  = 4'd6;
  localparam op_t OP_XOR = 4'd7;
  localparam op_t OP_NOT = 4'd8;
  localparam op_t OP_SHL = 4'd9;
  localparam op_t OP_SHR = 4'd10;

endpackage

// File: rtl/alu_divmod.sv
// Purpose : combinational W-bit unsigned divider (restoring long division).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; result valid whenever inputs are stable.
// Ports   : i_num dividend, i_den divisor, o_quo quotient, o_rem remainder,
//           o_dbz divisor is zero (quotient and remainder forced to 0).
module alu_divmod #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_num,
  input  logic [W-1:0] i_den,
  output logic [W-1:0] o_quo,
  output logic [W-1:0] o_rem,
  output logic         o_dbz
);

  logic [W:0]   w_part;  // one extra bit so the shifted partial remainder never truncates
  logic [W-1:0] w_quo;

  always_comb begin
    w_part = '0;
    w_quo  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_part = {w_part[W-1:0], i_num[i]};
      if (w_part >= {1'b0, i_den}) begin
        w_part   = w_part - {1'b0, i_den};
        w_quo[i] = 1'b1;
      end
    end
  end

  // A zero divisor would make every trial subtraction succeed; squash it here.
  assign o_dbz = (i_den == '0);
  assign o_quo = o_dbz ? '0 : w_quo;
  assign o_rem = o_dbz ? '0 : w_part[W-1:0];

endmodule

// File: rtl/alu.sv
// Purpose : W-bit unsigned ALU, 11 opcodes, registered result and flags.
// Latency : 1 cycle, one new operation accepted every cycle.
// Backpressure: none; fully pipelined, no handshake.
// Ports   : clk, rst (sync, active-high); A, B operands; Op opcode;
//           O result; OF_UND overflow/underflow; ERR div-by-zero or bad
//           opcode; ZERO result is zero and no error.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [OP_W-1:0] Op,
  output logic [W-1:0]    O,
  output logic            OF_UND,
  output logic            ERR,
  output logic            ZERO
);

  localparam logic [W:0] LP_W = (W+1)'(W);

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_shl;
  logic           w_b_ge_w;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic           w_dbz;
  logic [W-1:0]   w_res;
  logic           w_of;
  logic           w_err;

  logic [W-1:0]   r_o;
  logic           r_of;
  logic           r_err;
  logic           r_zero;

  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign w_prod   = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  // Widened left shift: bits pushed past W-1 land in the upper half.
  assign w_shl    = {{W{1'b0}}, A} << B;
  assign w_b_ge_w = ({1'b0, B} >= LP_W);

  alu_divmod #(.W(W)) u_divmod (
    .i_num (A),
    .i_den (B),
    .o_quo (w_quo),
    .o_rem (w_rem),
    .o_dbz (w_dbz)
  );

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    w_err = 1'b0;
    case (Op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_of  = w_sum[W];
      end
      OP_SUB: begin
        w_res = A - B;
        w_of  = (A < B);
      end
      OP_MUL: begin
        w_res = w_prod[W-1:0];
        w_of  = |w_prod[2*W-1:W];
      end
      OP_DIV: begin
        w_res = w_quo;
        w_err = w_dbz;
      end
      OP_MOD: begin
        w_res = w_rem;
        w_err = w_dbz;
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_NOT: w_res = ~A;
      OP_SHL: begin
        if (w_b_ge_w) begin
          // Every bit of A leaves the word.
          w_res = '0;
          w_of  = |A;
        end else begin
          w_res = w_shl[W-1:0];
          w_of  = |w_shl[2*W-1:W];
        end
      end
      OP_SHR: w_res = w_b_ge_w ? '0 : (A >> B);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o    <= '0;
      r_of   <= 1'b0;
      r_err  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_o    <= w_res;
      r_of   <= w_of & ~w_err;
      r_err  <= w_err;
      r_zero <= (w_res == '0) & ~w_err;
    end
  end

  assign O      = r_o;
  assign OF_UND = r_of;
  assign ERR    = r_err;
  assign ZERO   = r_zero;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] o;
    logic         of;
    logic         err;
    logic         zero;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic [3:0]   Op  = '0;
  logic [W-1:0] O;
  logic         OF_UND;
  logic         ERR;
  logic         ZERO;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  alu #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Op     (Op),
    .O      (O),
    .OF_UND (OF_UND),
    .ERR    (ERR),
    .ZERO   (ZERO)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op);
    vec_t   v;
    longint ia, ib, r;
    ia = longint'(a);
    ib = longint'(b);
    v.a = a; v.b = b; v.op = op;
    v.o = '0; v.of = 1'b0; v.err = 1'b0;
    case (int'(op))
      0: begin r = ia + ib; v.o = W'(r % MOD); v.of = (r >= MOD); end
      1: begin r = ia - ib; if (r < 0) r = r + MOD; v.o = W'(r); v.of = (ia < ib); end
      2: begin r = ia * ib; v.o = W'(r % MOD); v.of = (r >= MOD); end
      3: if (ib == 0) v.err = 1'b1; else v.o = W'(ia / ib);
      4: if (ib == 0) v.err = 1'b1; else v.o = W'(ia % ib);
      5: v.o = a & b;
      6: v.o = a | b;
      7: v.o = a ^ b;
      8: v.o = W'(MOD - 1 - ia);
      9: if (ib >= W) begin
           v.o = '0; v.of = (ia != 0);
         end else begin
           r = ia * (longint'(1) << ib);
           v.o = W'(r % MOD); v.of = (r >= MOD);
         end
      10: if (ib >= W) v.o = '0; else v.o = W'(ia / (longint'(1) << ib));
      default: v.err = 1'b1;
    endcase
    v.zero = (v.o == 0) && !v.err;
    return v;
  endfunction

  task automatic add_vec(input int a, input int b, input int op, input int o,
                         input int of, input int err, input int zero);
    vec_t v;
    v.a = W'(a); v.b = W'(b); v.op = 4'(op);
    v.o = W'(o); v.of = 1'(of); v.err = 1'(err); v.zero = 1'(zero);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input vec_t e);
    n_tests++;
    if ({O, OF_UND, ERR, ZERO} !== {e.o, e.of, e.err, e.zero}) begin
      n_fail++;
      $display("FAIL %s: got O=%0d OF=%b ERR=%b Z=%b, want O=%0d OF=%b ERR=%b Z=%b",
               name, O, OF_UND, ERR, ZERO, e.o, e.of, e.err, e.zero);
    end
  endtask

  task automatic drive(input vec_t v);
    A = v.a; B = v.b; Op = v.op;
  endtask

  initial begin
    vec_t zero_v;
    vec_t cur;
    vec_t prev;
    zero_v = '{a: '0, b: '0, op: '0, o: '0, of: 1'b0, err: 1'b0, zero: 1'b0};

    //        a    b   op   o   of err z
    add_vec(  5,  10,  0,  15, 0, 0, 0);
    add_vec(200, 200,  0, 144, 1, 0, 0);
    add_vec(255,   1,  0,   0, 1, 0, 1);
    add_vec( 14,  20,  1, 250, 1, 0, 0);
    add_vec( 14,   2,  1,  12, 0, 0, 0);
    add_vec( 14,   2,  2,  28, 0, 0, 0);
    add_vec( 14,  10,  2, 140, 0, 0, 0);
    add_vec(100,   6,  2,  88, 1, 0, 0);
    add_vec(  0,  10,  2,   0, 0, 0, 1);
    add_vec( 14,   2,  3,   7, 0, 0, 0);
    add_vec( 14,   2,  4,   0, 0, 0, 1);
    add_vec( 14,  14,  4,   0, 0, 0, 1);
    add_vec( 14,   0,  3,   0, 0, 1, 0);
    add_vec( 14,   0,  4,   0, 0, 1, 0);
    add_vec( 14,  14,  5,  14, 0, 0, 0);
    add_vec( 14,  12,  6,  14, 0, 0, 0);
    add_vec( 14,  12,  7,   2, 0, 0, 0);
    add_vec( 14,  99,  8, 241, 0, 0, 0);
    add_vec(129,   1,  9,   2, 1, 0, 0);
    add_vec(  1,   8,  9,   0, 1, 0, 1);
    add_vec(  1,   7,  9, 128, 0, 0, 0);
    add_vec(128,   9, 10,   0, 0, 0, 1);
    add_vec(128,   7, 10,   1, 0, 0, 0);
    add_vec(200, 100, 15,   0, 0, 1, 0);
    add_vec(  0,   0, 11,   0, 0, 1, 0);

    // Reset held two cycles with live operands: outputs stay cleared.
    rst = 1'b1; A = 8'd5; B = 8'd10; Op = OP_ADD;
    @(posedge clk); #1; check("reset_c1", zero_v);
    @(posedge clk); #1; check("reset_c2", zero_v);
    rst = 1'b0;
    @(posedge clk); #1; check("post_reset", model(8'd5, 8'd10, OP_ADD));

    // Table: applied back to back, each result checked one edge later.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      check($sformatf("tbl%0d", i), tbl[i]);
    end

    // Mid-stream reset discards the op sampled on the reset edge.
    A = 8'd14; B = 8'd10; Op = OP_MUL; rst = 1'b1;
    @(posedge clk); #1; check("mid_reset", zero_v);
    rst = 1'b0; A = 8'd200; B = 8'd200; Op = OP_ADD;
    @(posedge clk); #1; check("mid_reset_release", model(8'd200, 8'd200, OP_ADD));

    // Random back-to-back ops; also confirm outputs hold while inputs move.
    prev = model(8'd200, 8'd200, OP_ADD);
    for (int i = 0; i < 300; i++) begin
      cur.a  = W'($urandom_range(0, MOD - 1));
      cur.b  = (i % 3 == 0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, MOD - 1));
      cur.op = 4'($urandom_range(0, 15));
      drive(cur);
      #1; check($sformatf("hold%0d", i), prev);
      prev = model(cur.a, cur.b, cur.op);
      @(posedge clk); #1;
      check($sformatf("rnd%0d", i), prev);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterised W-bit unsigned arithmetic/logic unit with registered outputs. Takes two operands and a 4-bit opcode each cycle and delivers the result plus overflow/underflow, error and zero flags one clock later. Serves as the datapath compute element of the small processor/test datapath; fully pipelined, no handshake.

## Interface
- W, default 8: operand and result width in bits (W ≥ 2).

- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- A  input  W  operand A (unsigned)
- B  input  W  operand B (unsigned)
- Op  input  4  opcode
- O  output  W  registered result
- OF_UND  output  1  registered overflow (or underflow for subtract)
- ERR  output  1  registered error: divide/modulo by zero or undefined opcode
- ZERO  output  1  registered zero flag

## Operation
- Opcodes, all unsigned, result truncated to W bits:
  - 0 ADD: O = A+B; OF_UND = carry out of bit W-1.
  - 1 SUB: O = A−B mod 2^W; OF_UND = (A < B).
  - 2 MUL: O = low W bits of A·B; OF_UND = (A·B ≥ 2^W).
  - 3 DIV: O = A / B (floor). B=0 → O=0, ERR=1.
  - 4 MOD: O = A % B. B=0 → O=0, ERR=1.
  - 5 AND, 6 OR, 7 XOR: bitwise; OF_UND=0.
  - 8 NOT: O = ~A; B ignored.
  - 9 SHL: O = A << B[$clog2(W)-1:0]... shift amount = B; B ≥ W → O=0. OF_UND = any 1 bit shifted out.
  - 10 SHR: O = A >> B logical; B ≥ W → O=0; OF_UND=0.
  - 11–15: undefined → O=0, OF_UND=0, ERR=1.
- OF_UND is 0 for every opcode not listed as setting it, and 0 whenever ERR=1.
- ZERO = (O == 0) && !ERR, computed from the same-cycle next result.
- Division/modulo are combinational (single cycle); no multicycle divider.

## Timing
- All outputs registered; latency exactly 1 cycle: inputs sampled at rising edge k appear on outputs after edge k.
- New operation accepted every cycle; no valid/ready, no stall.
- rst high at a rising edge: O=0, OF_UND=0, ERR=0, ZERO=0 after that edge, regardless of A/B/Op. Reset dominates.
- Reset mid-stream: the operation sampled on the reset edge is discarded; first post-reset result is from the first edge with rst low.
- Outputs hold between edges; no combinational path from inputs to outputs.

## Structure
- Shared package: opcode constants (OP_ADD=0 … OP_SHR=10) and opcode width (4).
- One natural sub-module: alu_divmod (combinational W-bit unsigned divider producing quotient, remainder, div-by-zero flag). Everything else inline in alu: combinational result/flag logic, one output register stage.

## Test plan
- Reset: hold rst for 2 cycles with A=5,B=10,Op=0 → O=0, all flags 0; release → next cycle O=15, ZERO=0.
- ADD/SUB (W=8): 5+10 → 15; 200+200 → O=144, OF_UND=1; 14−20 → O=250, OF_UND=1; 14−2 → O=12, OF_UND=0.
- MUL: 14·2 → 28; 14·10 → 140, OF_UND=0; 100·6 → O=88, OF_UND=1; 0·10 → O=0, ZERO=1.
- DIV/MOD: 14/2 → 7; 14%2 → O=0, ZERO=1; 14%14 → ZERO=1; 14/0 → O=0, ERR=1, ZERO=0.
- Logic/shift: 14 AND 14 → 14; 14 OR 12 → 14; 14 XOR 12 → 2; NOT 14 → 241; 0x81 SHL 1 → O=2, OF_UND=1; 0x80 SHR 9 → 0.
- Opcode 15 with any operands → O=0, ERR=1; back-to-back ops on consecutive cycles each appear exactly one cycle later.
